sqrt_seq_fsm: RTL
=================

# sqrt_seq_fsm

State sequencer for the square-root unit. Holds the 4-bit controller state, advances it on each clock according to `start`, the datapath loop-exit flag and an iteration limit, and drives the state bits {A,B,C,D} into the controller decoder. The decoder turns those bits into output enables, ALU op selects and register loads. The block also provides the start/done handshake to the host logic.

## Interface
Parameters:
- `ITER_MAX`, default 16: maximum loop iterations before a forced exit.
- `CW`, default 5: iteration counter width. Must hold `ITER_MAX`.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a new computation. Sampled only in IDLE.
- `cond`, in, 1: datapath loop-exit flag (1 = root found). Sampled only in S7.
- `state_o`, out, 4: {A,B,C,D} to the decoder. `state_o[3]` = A, `state_o[0]` = D.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: high for exactly one cycle, while in DONE.
- `overrun`, out, 1: set when the loop exited on `ITER_MAX` rather than `cond`. Cleared on next accepted `start`.
- `iter_cnt`, out, CW: number of completed loop passes.

## Operation
State codes: IDLE=0000, S1=0001, S2=0010, S3=0011, S4=0100, S5=0101, S6=0110, S7=0111, DONE=1000.

Transitions:
- IDLE → S1 when `start`=1. Otherwise stay. Entering S1 clears `iter_cnt` and `overrun`.
- S1 → S2 → S3 → S4: unconditional init/load phase.
- S4 → S5 → S6 → S7: unconditional loop body.
- In S7, `iter_cnt` increments on the exit edge (saturating at `ITER_MAX`).
- S7 → DONE if `cond`=1.
- S7 → DONE with `overrun`←1 if `cond`=0 and `iter_cnt`+1 = `ITER_MAX`.
- S7 → S4 otherwise.
- DONE → IDLE unconditionally.
- Codes 1001–1111 (illegal) → IDLE next cycle. `busy` stays high while the illegal code is held.

Handshake rules:
- `start` while `busy` is ignored.
- `start` held high continuously restarts immediately after each IDLE cycle.
- `cond` is ignored outside S7.

Outputs and reset:
- All outputs are registered or decoded directly from the state register. No combinational path from `start` or `cond` to any output.
- Reset (any time, including mid-loop) forces state=IDLE, `busy`=0, `done`=0, `overrun`=0, `iter_cnt`=0 immediately.

## Timing
- `start` sampled high at edge k → `state_o`=S1 after edge k, `busy`=1 from the same edge.
- Total latency for N loop passes: 3 (S1–S3) + 4N (S4–S7) + 1 (DONE) cycles from the first non-IDLE cycle to return to IDLE.
- `done` asserts during the single DONE cycle. Result is valid on the datapath during that cycle (decoder drives OE[10]).
- Minimum start-to-start spacing: 4N+5 cycles (including one IDLE cycle).

## Configuration
- `SQRT_SEQ_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - Transitions out of every state except IDLE occur only on cycles with `step`=1; otherwise the state holds.
  - `iter_cnt` increments only on a stepped S7 exit.
  - `done` stays high for the whole DONE dwell.
- Undefined: no `step` port. The sequencer free-runs as described above.

## Structure
- Shared package `sqrt_pkg` holds:
  - the nine state code localparams (IDLE…DONE);
  - the state width (4);
  - the `sqrt_state_t` typedef.
- The decoder consumes the same codes from `sqrt_pkg`.
- One sub-module, `sqrt_iter_counter`: clear, increment-enable, saturating at `ITER_MAX`, `at_limit` flag.

## Test plan
- Reset mid-loop:
  - assert `rst_n`=0 while state=S6 → all outputs zero in the same cycle;
  - after release with `start`=0 → state remains 0000.
- Single pass:
  - `start` pulse, `cond`=1 at first S7 → state sequence 0001,0010,0011,0100,0101,0110,0111,1000,0000;
  - `done` high only at 1000; `iter_cnt`=1; `overrun`=0.
- Three passes:
  - `cond`=1 only at third S7 → DONE reached 15 cycles after S1; `iter_cnt`=3.
- Overrun with `ITER_MAX`=4:
  - `cond` held 0 → exit after fourth S7; `overrun`=1; `iter_cnt`=4;
  - next `start` clears `overrun` on entry to S1.
- Busy and gating:
  - `start` pulses in S2 and S5 → no effect on sequence;
  - `cond`=1 pulsed in S5 → ignored, loop continues.
- Step mode (macro defined):
  - `step`=0 for 10 cycles in S3 → state holds 0011;
  - one `step` pulse → 0100.

Source files
------------

// File: rtl/sqrt_seq_fsm_pkg.sv
// Shared state encoding for the square-root sequencer and its controller decoder.
package sqrt_pkg;

  localparam int SQRT_SW = 4;

  localparam logic [SQRT_SW-1:0] IDLE = 4'b0000;
  localparam logic [SQRT_SW-1:0] S1   = 4'b0001;
  localparam logic [SQRT_SW-1:0] S2   = 4'b0010;
  localparam logic [SQRT_SW-1:0] S3   = 4'b0011;
  localparam logic [SQRT_SW-1:0] S4   = 4'b0100;
  localparam logic [SQRT_SW-1:0] S5   = 4'b0101;
  localparam logic [SQRT_SW-1:0] S6   = 4'b0110;
  localparam logic [SQRT_SW-1:0] S7   = 4'b0111;
  localparam logic [SQRT_SW-1:0] DONE = 4'b1000;

  typedef enum logic [SQRT_SW-1:0] {
    ST_IDLE = IDLE,
    ST_S1   = S1,
    ST_S2   = S2,
    ST_S3   = S3,
    ST_S4   = S4,
    ST_S5   = S5,
    ST_S6   = S6,
    ST_S7   = S7,
    ST_DONE = DONE
  } sqrt_state_t;

endpackage

// File: rtl/sqrt_seq_fsm_iter_counter.sv
// Loop-pass counter: synchronous clear, enabled increment saturating at ITER_MAX,
// and a flag that is high when the next increment reaches ITER_MAX.
module sqrt_iter_counter #(
  parameter int ITER_MAX = 16,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_at_limit
);

  localparam logic [CW-1:0] LIMIT    = CW'(ITER_MAX);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(ITER_MAX - 1);

  logic [CW-1:0] r_cnt;

  // Count register with clear priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt >= LIMIT_M1);

endmodule

// File: rtl/sqrt_seq_fsm.sv
// State sequencer for the square-root unit with start/done handshake.
// Optional single-step gating when SQRT_SEQ_STEP_EN is defined (adds port `step`).
module sqrt_seq_fsm
  import sqrt_pkg::*;
#(
  parameter int ITER_MAX = 16,
  parameter int CW       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cond,
`ifdef SQRT_SEQ_STEP_EN
  input  logic               step,
`endif
  output logic [SQRT_SW-1:0] state_o,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic [CW-1:0]      iter_cnt
);

  sqrt_state_t r_state;
  sqrt_state_t w_next;
  logic        r_busy;
  logic        r_done;
  logic        r_overrun;
  logic        w_adv;
  logic        w_clr;
  logic        w_inc;
  logic        w_set_ovr;
  logic        w_at_limit;

`ifdef SQRT_SEQ_STEP_EN
  assign w_adv = step;
`else
  assign w_adv = 1'b1;
`endif

  // Next-state and counter/overrun control
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    w_set_ovr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_S1;
          w_clr  = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_S1:   if (w_adv) w_next = ST_S2;   else w_next = r_state;
      ST_S2:   if (w_adv) w_next = ST_S3;   else w_next = r_state;
      ST_S3:   if (w_adv) w_next = ST_S4;   else w_next = r_state;
      ST_S4:   if (w_adv) w_next = ST_S5;   else w_next = r_state;
      ST_S5:   if (w_adv) w_next = ST_S6;   else w_next = r_state;
      ST_S6:   if (w_adv) w_next = ST_S7;   else w_next = r_state;
      ST_S7: begin
        if (w_adv) begin
          w_inc = 1'b1;
          if (cond) begin
            w_next = ST_DONE;
          end else if (w_at_limit) begin
            w_next    = ST_DONE;
            w_set_ovr = 1'b1;
          end else begin
            w_next = ST_S4;
          end
        end else begin
          w_next = r_state;
        end
      end
      ST_DONE: if (w_adv) w_next = ST_IDLE; else w_next = r_state;
      // Illegal codes recover unconditionally, even with stepping held off
      default: w_next = ST_IDLE;
    endcase
  end

  // State and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      if (w_clr) begin
        r_overrun <= 1'b0;
      end else if (w_set_ovr) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  sqrt_iter_counter #(
    .ITER_MAX (ITER_MAX),
    .CW       (CW)
  ) u_iter_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_inc      (w_inc),
    .o_cnt      (iter_cnt),
    .o_at_limit (w_at_limit)
  );

  assign state_o = r_state;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule
